// File: rtl/kamus_rf_pkg.sv
// Shared types, defaults and helpers for the multi-port register file
// and its pending-write scoreboard.
package kamus_rf_pkg;
    localparam int RF_XLEN    = 32;
    localparam int RF_NR_REGS = 32;
    localparam int RF_AW      = $clog2(RF_NR_REGS);
    localparam int ZERO_REG   = 0;

    // popcount operates on a fixed-width vector; callers zero-pad to POP_MAX
    localparam int POP_MAX = 256;
    localparam int POP_W   = 9;

    typedef logic [RF_AW-1:0]   reg_addr_t;
    typedef logic [RF_XLEN-1:0] xlen_t;

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            c = c + {{(POP_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue,
// cleared at writeback (set wins), with a registered population count.
module rf_scoreboard
    import kamus_rf_pkg::*;
#(
    parameter int NR_REGS = RF_NR_REGS,
    parameter int NR_WR   = 1,
    localparam int AW     = $clog2(NR_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NR_WR-1:0]    wr_en_i,
    input  logic [NR_WR*AW-1:0] wr_addr_i,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [NR_REGS-1:0]  busy_vec_o,
    output logic [AW:0]         busy_cnt_o
);

    logic [NR_REGS-1:0] busy_q, busy_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [POP_MAX-1:0] pop_pad;
    logic [POP_W-1:0]   pop_full;

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NR_WR; w++) begin
            if (wr_en_i[w]) busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
        end
        // A new producer supersedes any writeback landing in the same cycle
        if (iss_valid_i && (iss_rd_i != AW'(ZERO_REG))) busy_d[iss_rd_i] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_comb begin
        pop_pad = '0;
        pop_pad[NR_REGS-1:0] = busy_d;
    end

    assign pop_full = popcount(pop_pad);
    assign cnt_d    = pop_full[AW:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file (x0 hardwired to zero) with a pending-write
// scoreboard. Define KAMUS_RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb
    import kamus_rf_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int NR_REGS = RF_NR_REGS,
    parameter int NR_RD   = 2,
    parameter int NR_WR   = 1,
    localparam int AW     = $clog2(NR_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NR_RD*AW-1:0]   rd_addr_i,
    output logic [NR_RD*XLEN-1:0] rd_data_o,
    output logic [NR_RD-1:0]      rd_busy_o,
    input  logic [NR_WR-1:0]      wr_en_i,
    input  logic [NR_WR*AW-1:0]   wr_addr_i,
    input  logic [NR_WR*XLEN-1:0] wr_data_i,
    input  logic                  iss_valid_i,
    input  logic [AW-1:0]         iss_rd_i,
    output logic [NR_REGS-1:0]    busy_vec_o,
    output logic [AW:0]           busy_cnt_o
);

    logic [XLEN-1:0]    mem_q [NR_REGS];
    logic [NR_REGS-1:0] busy_q;

    // Later ports overwrite earlier ones, so the highest-indexed port wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR_REGS; r++) mem_q[r] <= '0;
        end else begin
            for (int w = 0; w < NR_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != AW'(ZERO_REG))) begin
                    mem_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NR_REGS (NR_REGS),
        .NR_WR   (NR_WR)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .busy_vec_o  (busy_q),
        .busy_cnt_o  (busy_cnt_o)
    );

    assign busy_vec_o = busy_q;

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbusy;

        assign ra = rd_addr_i[k*AW +: AW];

        always_comb begin
            rdat  = mem_q[ra];
            rbusy = busy_q[ra];
`ifdef KAMUS_RF_BYPASS_EN
            for (int w = 0; w < NR_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
                    rdat  = wr_data_i[w*XLEN +: XLEN];
                    rbusy = 1'b0;
                end
            end
`endif
            // Gating on reset keeps forwarded data from leaking out while held in reset
            if ((ra == AW'(ZERO_REG)) || !rst_ni) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = rdat;
        assign rd_busy_o[k]              = rbusy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (NR_WR=2) with a queue scoreboard
// and a small reference model for the randomized section.
module tb_regfile_mp_sb;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [2*AW-1:0] rd_addr_i;
    logic [2*XLEN-1:0] rd_data_o;
    logic [1:0]      rd_busy_o;
    logic [1:0]      wr_en_i;
    logic [2*AW-1:0] wr_addr_i;
    logic [2*XLEN-1:0] wr_data_i;
    logic            iss_valid_i;
    logic [AW-1:0]   iss_rd_i;
    logic [NR-1:0]   busy_vec_o;
    logic [AW:0]     busy_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    regfile_mp_sb #(.XLEN(XLEN), .NR_REGS(NR), .NR_RD(2), .NR_WR(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_busy_o   (rd_busy_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .busy_vec_o  (busy_vec_o),
        .busy_cnt_o  (busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        conflict_chk: assert (!(rst_ni && wr_en_i == 2'b11 && wr_addr_i[AW-1:0] == wr_addr_i[2*AW-1:AW]))
            else $warning("write-port conflict on x%0d, port 1 takes priority", wr_addr_i[AW-1:0]);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        wr_en_i     = '0;
        iss_valid_i = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en_i[p]            = 1'b1;
        wr_addr_i[p*AW +: AW] = AW'(a);
        wr_data_i[p*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        iss_valid_i = 1'b1;
        iss_rd_i    = AW'(a);
    endtask

    task automatic rd(input int p, input int a);
        rd_addr_i[p*AW +: AW] = AW'(a);
    endtask

    task automatic chk(input string name, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic do_reset;
        idle();
        rst_ni = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        rd(0, 5); rd(1, 6);
        #1;
        exp_q.push_back(32'h0); chk("reset_busy_vec", busy_vec_o);
        exp_q.push_back(32'h0); chk("reset_busy_cnt", 32'(busy_cnt_o));
        wr(0, 5, 32'hDEADBEEF); iss(6);
        tick(); idle();
        #1;
        exp_q.push_back(32'hDEADBEEF); chk("pre_reset_x5", rd_data_o[31:0]);
        exp_q.push_back(32'h1);        chk("pre_reset_busy6", 32'(rd_busy_o[1]));
        rst_ni = 1'b0;
        #1;
        exp_q.push_back(32'h0); chk("async_reset_x5", rd_data_o[31:0]);
        exp_q.push_back(32'h0); chk("async_reset_busy_vec", busy_vec_o);
        exp_q.push_back(32'h0); chk("async_reset_cnt", 32'(busy_cnt_o));
        exp_q.push_back(32'h0); chk("async_reset_rd_busy", 32'(rd_busy_o));
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_x0;
        wr(0, 0, 32'h1234); iss(0);
        rd(0, 0);
        tick(); idle();
        #1;
        exp_q.push_back(32'h0); chk("x0_data", rd_data_o[31:0]);
        exp_q.push_back(32'h0); chk("x0_busy", 32'(rd_busy_o[0]));
        exp_q.push_back(32'h0); chk("x0_busy_vec", busy_vec_o);
    endtask

    task automatic test_latency;
        wr(0, 3, 32'h1);
        tick(); idle();
        wr(0, 3, 32'hA5A5A5A5); rd(1, 3);
        #1;
`ifdef KAMUS_RF_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h1);
`endif
        chk("latency_cycle_n", rd_data_o[63:32]);
        tick(); idle();
        #1;
        exp_q.push_back(32'hA5A5A5A5); chk("latency_cycle_n1", rd_data_o[63:32]);
    endtask

    task automatic test_scoreboard;
        iss(7);
        tick(); idle();
        rd(0, 7);
        #1;
        exp_q.push_back(32'h1); chk("sb_busy7", 32'(busy_vec_o[7]));
        exp_q.push_back(32'h1); chk("sb_cnt1", 32'(busy_cnt_o));
        exp_q.push_back(32'h1); chk("sb_rd_busy0", 32'(rd_busy_o[0]));
        wr(0, 7, 32'h77);
        #1;
`ifdef KAMUS_RF_BYPASS_EN
        exp_q.push_back(32'h0);
`else
        exp_q.push_back(32'h1);
`endif
        chk("sb_rd_busy_during_wb", 32'(rd_busy_o[0]));
        tick(); idle();
        #1;
        exp_q.push_back(32'h0);  chk("sb_busy7_cleared", 32'(busy_vec_o[7]));
        exp_q.push_back(32'h0);  chk("sb_cnt0", 32'(busy_cnt_o));
        exp_q.push_back(32'h0);  chk("sb_rd_busy_cleared", 32'(rd_busy_o[0]));
        exp_q.push_back(32'h77); chk("sb_x7_data", rd_data_o[31:0]);
    endtask

    task automatic test_set_clear;
        iss(9); wr(0, 9, 32'h99);
        tick(); idle();
        rd(0, 9);
        #1;
        exp_q.push_back(32'h1);  chk("setclr_busy9", 32'(busy_vec_o[9]));
        exp_q.push_back(32'h1);  chk("setclr_cnt", 32'(busy_cnt_o));
        exp_q.push_back(32'h99); chk("setclr_data", rd_data_o[31:0]);
        wr(1, 9, 32'h999);
        tick(); idle();
    endtask

    task automatic test_conflict;
        iss(4);
        tick(); idle();
        wr(0, 4, 32'h11); wr(1, 4, 32'h22);
        tick(); idle();
        rd(1, 4);
        #1;
        exp_q.push_back(32'h22); chk("conflict_data", rd_data_o[63:32]);
        exp_q.push_back(32'h0);  chk("conflict_busy4", 32'(busy_vec_o[4]));
    endtask

    task automatic test_fill;
        do_reset();
        for (int r = 1; r < NR; r++) begin
            iss(r);
            tick();
        end
        idle();
        #1;
        exp_q.push_back(32'd31);        chk("fill_cnt", 32'(busy_cnt_o));
        exp_q.push_back(32'hFFFFFFFE);  chk("fill_vec", busy_vec_o);
        iss(0);
        tick(); idle();
        #1;
        exp_q.push_back(32'd31);        chk("fill_x0_cnt", 32'(busy_cnt_o));
        exp_q.push_back(32'hFFFFFFFE);  chk("fill_x0_vec", busy_vec_o);
    endtask

    task automatic test_random;
        logic [31:0] mem [NR];
        logic [NR-1:0] busy;
        int a0, a1, ai, r0, r1;
        logic e0, e1, ev;
        logic [31:0] d0, d1;
        do_reset();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        busy = '0;
        for (int c = 0; c < 300; c++) begin
            e0 = 1'($urandom); e1 = 1'($urandom); ev = 1'($urandom);
            a0 = $urandom_range(0, NR-1); a1 = $urandom_range(0, NR-1);
            if (e0 && e1 && a0 == a1) a1 = (a0 + 1) % NR;
            ai = $urandom_range(0, NR-1);
            d0 = $urandom; d1 = $urandom;
            if (e0) wr(0, a0, d0);
            if (e1) wr(1, a1, d1);
            if (ev) iss(ai);
            if (e0) begin busy[a0] = 1'b0; if (a0 != 0) mem[a0] = d0; end
            if (e1) begin busy[a1] = 1'b0; if (a1 != 0) mem[a1] = d1; end
            if (ev && ai != 0) busy[ai] = 1'b1;
            exp_q.push_back(busy);
            exp_q.push_back(32'($countones(busy)));
            tick(); idle();
            chk("rand_busy_vec", busy_vec_o);
            chk("rand_busy_cnt", 32'(busy_cnt_o));
            r0 = $urandom_range(0, NR-1); r1 = $urandom_range(0, NR-1);
            rd(0, r0); rd(1, r1);
            #1;
            exp_q.push_back(mem[r0]); chk("rand_rd0_data", rd_data_o[31:0]);
            exp_q.push_back(mem[r1]); chk("rand_rd1_data", rd_data_o[63:32]);
            exp_q.push_back(32'({busy[r1], busy[r0]})); chk("rand_rd_busy", 32'(rd_busy_o));
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        rd_addr_i = '0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
        iss_valid_i = 1'b0; iss_rd_i = '0;
        test_reset();
        test_x0();
        test_latency();
        test_scoreboard();
        test_set_clear();
        test_conflict();
        test_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
